// File: rtl/dsp_pkg.sv
// Shared helpers for the int8 dot-product datapath: tree sizing functions and default widths.
package dsp_pkg;

  localparam int DEFAULT_TREE_SIZE = 19;

  function automatic int tree_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Node count entering level k of a pairwise tree with n leaves: ceil(n / 2^k).
  function automatic int level_count(input int n, input int k);
    int c;
    c = n;
    for (int i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered level of the reduction tree: pairwise signed adds, odd leftover passed through.
module adder_tree_stage
  import dsp_pkg::*;
#(
  parameter int W = DEFAULT_TREE_SIZE,
  parameter int N = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] din  [N],
  output logic signed [W:0]   dout [(N+1)/2]
);

  localparam int NO = (N + 1) / 2;

  logic signed [W:0] sum_c [NO];
  logic signed [W:0] sum_p [NO];

  function automatic logic signed [W:0] sext1(input logic signed [W-1:0] x);
    return {x[W-1], x};
  endfunction

  // The unpaired last element is only widened so it keeps the same latency as the sums.
  always_comb begin
    for (int j = 0; j < NO; j++) sum_c[j] = '0;
    for (int j = 0; j < N / 2; j++) sum_c[j] = sext1(din[2*j]) + sext1(din[2*j+1]);
    if (N % 2 == 1) sum_c[NO-1] = sext1(din[N-1]);
  end

  // ---- stage register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NO; j++) sum_p[j] <= '0;
    end else begin
      sum_p <= sum_c;
    end
  end

  assign dout = sum_p;

endmodule

// File: rtl/pipelined_signed_adder_tree.sv
// Fully pipelined full-precision signed sum of NUM operands, one register level per tree level.
module pipelined_signed_adder_tree
  import dsp_pkg::*;
#(
  parameter int SIZE  = DEFAULT_TREE_SIZE,
  parameter int NUM   = 16,
  parameter int LEVELS = tree_levels(NUM),
  parameter int OUT_W  = SIZE + LEVELS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [SIZE-1:0] din [NUM],
  output logic signed [OUT_W-1:0] dout
);

  if (LEVELS == 0) begin : g_passthru
    // A single operand needs no tree; clock and reset are deliberately left unused.
    logic unused_ok;
    assign unused_ok = clk ^ rst_n;
    assign dout = din[0];
  end else begin : g_tree
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int W_IN  = SIZE + k;
      localparam int N_IN  = level_count(NUM, k);
      localparam int N_OUT = level_count(NUM, k + 1);

      logic signed [W_IN:0] sum_p [N_OUT];

      if (k == 0) begin : g_first
        adder_tree_stage #(
          .W(W_IN),
          .N(N_IN)
        ) u_stage (
          .clk  (clk),
          .rst_n(rst_n),
          .din  (din),
          .dout (sum_p)
        );
      end else begin : g_next
        adder_tree_stage #(
          .W(W_IN),
          .N(N_IN)
        ) u_stage (
          .clk  (clk),
          .rst_n(rst_n),
          .din  (g_lvl[k-1].sum_p),
          .dout (sum_p)
        );
      end
    end

    // ---- final level drives the output directly ----
    assign dout = g_lvl[LEVELS-1].sum_p[0];
  end

endmodule

// File: tb/tb_pipelined_signed_adder_tree.sv
// Directed and streaming checks of the adder tree across several operand counts.
module tb_pipelined_signed_adder_tree;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic signed [18:0] din6  [6];
  logic signed [21:0] dout6;
  logic signed [18:0] din5  [5];
  logic signed [21:0] dout5;
  logic signed [18:0] din3  [3];
  logic signed [20:0] dout3;
  logic signed [18:0] din16 [16];
  logic signed [22:0] dout16;
  logic signed [18:0] din1  [1];
  logic signed [18:0] dout1;

  pipelined_signed_adder_tree #(.SIZE(19), .NUM(6))  u6  (.clk(clk), .rst_n(rst_n), .din(din6),  .dout(dout6));
  pipelined_signed_adder_tree #(.SIZE(19), .NUM(5))  u5  (.clk(clk), .rst_n(rst_n), .din(din5),  .dout(dout5));
  pipelined_signed_adder_tree #(.SIZE(19), .NUM(3))  u3  (.clk(clk), .rst_n(rst_n), .din(din3),  .dout(dout3));
  pipelined_signed_adder_tree #(.SIZE(19), .NUM(16)) u16 (.clk(clk), .rst_n(rst_n), .din(din16), .dout(dout16));
  pipelined_signed_adder_tree #(.SIZE(19), .NUM(1))  u1  (.clk(clk), .rst_n(rst_n), .din(din1),  .dout(dout1));

  typedef struct {
    string  name;
    int     inst;
    int     op [6];
    longint exp;
  } vec_t;

  vec_t   tbl [10];
  int     nvec = 0;
  int     nmis = 0;
  longint hist [4];

  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int     lat;
    longint act;
    lat = (v.inst == 3) ? 2 : 3;
    case (v.inst)
      6:       for (int j = 0; j < 6; j++) din6[j] = v.op[j][18:0];
      5:       for (int j = 0; j < 5; j++) din5[j] = v.op[j][18:0];
      default: for (int j = 0; j < 3; j++) din3[j] = v.op[j][18:0];
    endcase
    repeat (lat) @(posedge clk);
    #1;
    case (v.inst)
      6:       act = longint'(dout6);
      5:       act = longint'(dout5);
      default: act = longint'(dout3);
    endcase
    check(v.name, act, v.exp);
  endtask

  initial begin
    longint s;

    tbl[0] = '{"n6_all_p1",     6, '{1, 1, 1, 1, 1, 1},                                    6};
    tbl[1] = '{"n6_all_min",    6, '{-262144, -262144, -262144, -262144, -262144, -262144}, -1572864};
    tbl[2] = '{"n6_all_max",    6, '{262143, 262143, 262143, 262143, 262143, 262143},       1572858};
    tbl[3] = '{"n6_cancel",     6, '{1, -1, 2, -2, 3, -3},                                  0};
    tbl[4] = '{"n6_mixed",      6, '{100, 200, -50, 7, 0, -1},                              256};
    tbl[5] = '{"n5_odd",        5, '{1, 2, 3, 4, 100, 0},                                   110};
    tbl[6] = '{"n5_all_min",    5, '{-262144, -262144, -262144, -262144, -262144, 0},       -1310720};
    tbl[7] = '{"n3_odd",        3, '{-7, 5, 9, 0, 0, 0},                                    7};
    tbl[8] = '{"n3_all_max",    3, '{262143, 262143, 262143, 0, 0, 0},                      786429};
    tbl[9] = '{"n3_min_plus1",  3, '{-262144, 1, 0, 0, 0, 0},                               -262143};

    rst_n = 1'b0;
    for (int j = 0; j < 6; j++)  din6[j]  = '0;
    for (int j = 0; j < 5; j++)  din5[j]  = '0;
    for (int j = 0; j < 3; j++)  din3[j]  = '0;
    for (int j = 0; j < 16; j++) din16[j] = '0;
    din1[0] = 19'sd3;
    for (int i = 0; i < 4; i++) hist[i] = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_n6",  longint'(dout6),  0);
    check("rst_n5",  longint'(dout5),  0);
    check("rst_n3",  longint'(dout3),  0);
    check("rst_n16", longint'(dout16), 0);
    check("rst_n1_passthru", longint'(dout1), 3);
    rst_n = 1'b1;

    // First post-reset vector: zero until it has crossed all three levels.
    for (int j = 0; j < 6; j++) din6[j] = 19'sd1;
    @(posedge clk); #1; check("n6_lat_edge1", longint'(dout6), 0);
    @(posedge clk); #1; check("n6_lat_edge2", longint'(dout6), 0);
    @(posedge clk); #1; check("n6_lat_edge3", longint'(dout6), 6);

    // Back-to-back random vectors with an asynchronous reset pulse mid-stream.
    for (int i = 0; i < 10000; i++) begin
      s = 0;
      for (int j = 0; j < 16; j++) begin
        din16[j] = 19'($urandom);
        s += longint'(din16[j]);
      end
      @(posedge clk);
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = s;
      #1;
      check("n16_stream", longint'(dout16), hist[3]);
      if (i == 500) begin
        #2 rst_n = 1'b0;
        #1;
        check("n16_async_rst", longint'(dout16), 0);
        check("n6_async_rst",  longint'(dout6),  0);
        for (int k = 0; k < 4; k++) hist[k] = 0;
        @(posedge clk);
        #1;
        check("n16_rst_hold", longint'(dout16), 0);
        #2 rst_n = 1'b1;
      end
    end

    foreach (tbl[i]) run_vec(tbl[i]);

    // Single operand: combinational, reset-independent.
    rst_n = 1'b0;
    din1[0] = -19'sd5;
    #1;
    check("n1_in_reset", longint'(dout1), -5);
    check("n3_in_reset", longint'(dout3), 0);
    din1[0] = 19'sd77;
    rst_n = 1'b1;
    #1;
    check("n1_after_reset", longint'(dout1), 77);
    din1[0] = -19'sd262144;
    #1;
    check("n1_min", longint'(dout1), -262144);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
